audio_loop_proc: RTL and testbench

Parametrised per-channel audio processing stage between the codec controller's receive side (`adc_data`/`rx_done`) and its transmit side (`dac_data`). It replaces the direct ADC→DAC loopback with:
- per-channel gain;
- saturation;
- an optional feedback echo built on a shared delay RAM.

One time-multiplexed datapath processes the channels sequentially, once per audio frame.

---
 rtl/audio_pkg.sv | 19 +
 rtl/audio_dly_ram.sv | 31 +++
 rtl/audio_loop_proc.sv | 237 +++++++++++++++++++++++
 tb/tb_audio_loop_proc.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: FSM state type and fixed shift constants shared by the audio loop stage.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int FB_W     = 32'sd8;
    localparam int FB_SHIFT = 32'sd8;

    // Gain is fixed point with unity at 2^(gw-2), leaving one bit of headroom above x2.
    function automatic int unity_shift(input int gw);
        return gw - 32'sd2;
    endfunction

endpackage

// File: rtl/audio_dly_ram.sv
// audio_dly_ram: simple dual-port echo delay line, registered read returning old data on collision.
// Present only in builds with AUDIO_ECHO_EN defined; contents are never reset.
`ifdef AUDIO_ECHO_EN
module audio_dly_ram #(
    parameter int DW = 16,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    localparam int WORDS = 32'sd1 << AW;

    logic [DW-1:0] mem_r [WORDS];
    logic [DW-1:0] rd_data_r;

    // Write port and registered read port; the read samples the array before this edge's write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
        rd_data_r <= mem_r[rd_addr];
    end

    assign rd_data = rd_data_r;

endmodule
`endif

// File: rtl/audio_loop_proc.sv
// audio_loop_proc: per-channel gain, saturation and feedback echo between codec rx and tx.
// Define AUDIO_ECHO_EN to build the echo path (delay RAM, fill guard, echo_fb/echo_dly).
module audio_loop_proc
    import audio_pkg::*;
#(
    parameter int DW    = 16,
    parameter int CH    = 2,
    parameter int GW    = 8,
    parameter int DEPTH = 1024
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [CH*DW-1:0]         in_data,
    input  logic                     in_valid,
    input  logic [CH*GW-1:0]         gain,
    input  logic [7:0]               echo_fb,
    input  logic [$clog2(DEPTH)-1:0] echo_dly,
    input  logic                     bypass,
    output logic [CH*DW-1:0]         out_data,
    output logic                     out_valid,
    output logic [CH-1:0]            clip,
    output logic                     busy,
    output logic                     overrun
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int GS  = unity_shift(GW);
    localparam int PW  = DW + GW + 1;
    localparam int EW  = DW + FB_W + 1;
    localparam int SW  = ((PW > EW) ? PW : EW) + 1;

    localparam logic signed [SW-1:0] SMAX    = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN    = ~SMAX;
    localparam logic [CHW-1:0]       LAST_CH = CHW'(CH - 1);

    state_t                  state_r, state_nx_s;
    logic [CHW-1:0]          ch_r;
    logic [CH*DW-1:0]        x_r, shadow_r, out_data_r;
    logic [CH*GW-1:0]        gain_r;
    logic [CH-1:0]           clip_sh_r, clip_r;
    logic                    bypass_r, out_valid_r, busy_r, overrun_r;
    logic signed [DW-1:0]    x_s, y_s;
    logic [GW-1:0]           g_cur_s;
    logic signed [PW-1:0]    prod_s, g_s;
    logic signed [SW-1:0]    sum_s;
    logic                    y_clip_s, accept_s, last_ch_s, store_s;

    function automatic logic [DW:0] sat_clip(input logic signed [SW-1:0] v);
        logic [DW:0] r;
        if (v > SMAX) begin
            r = {1'b1, SMAX[DW-1:0]};
        end else if (v < SMIN) begin
            r = {1'b1, SMIN[DW-1:0]};
        end else begin
            r = {1'b0, v[DW-1:0]};
        end
        return r;
    endfunction

    assign x_s       = x_r[int'(ch_r)*DW +: DW];
    assign g_cur_s   = gain_r[int'(ch_r)*GW +: GW];
    assign prod_s    = PW'(x_s) * PW'($signed({1'b0, g_cur_s}));
    assign g_s       = prod_s >>> GS;
    assign accept_s  = (state_r == IDLE) && in_valid && !busy_r;
    assign last_ch_s = (ch_r == LAST_CH);

`ifdef AUDIO_ECHO_EN
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    logic [AW-1:0]        wr_ptr_r, dly_r;
    logic [AW:0]          fill_r, d_len_s;
    logic [7:0]           fb_r;
    logic signed [SW-1:0] g_r;
    logic [DW-1:0]        rd_data_s;
    logic signed [DW-1:0] d_s;
    logic signed [EW-1:0] e_s;

    // Delay lines younger than the requested delay read as silence, so stale RAM never leaks out.
    assign d_len_s = (dly_r == '0) ? DEPTH_L : {1'b0, dly_r};
    assign d_s     = (d_len_s > fill_r) ? '0 : rd_data_s;
    assign e_s     = (EW'(d_s) * EW'($signed({1'b0, fb_r}))) >>> FB_SHIFT;
    assign sum_s   = g_r + SW'(e_s);
    assign store_s = (state_r == ADD);

    audio_dly_ram #(
        .DW (DW),
        .AW (AW + CHW)
    ) u_ram (
        .clk     (sys_clk),
        .wr_en   (store_s),
        .wr_addr ({wr_ptr_r, ch_r}),
        .wr_data (y_s),
        .rd_addr ({wr_ptr_r - dly_r, ch_r}),
        .rd_data (rd_data_s)
    );

    // Echo-side registers: frame parameters, gain product hand-off, write pointer and fill count.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            fb_r     <= 8'd0;
            dly_r    <= '0;
            g_r      <= '0;
            wr_ptr_r <= '0;
            fill_r   <= '0;
        end else begin
            if (accept_s) begin
                fb_r  <= echo_fb;
                dly_r <= echo_dly;
            end
            if (state_r == MUL) begin
                g_r <= SW'(g_s);
            end
            if (state_r == DONE) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
                if (fill_r != DEPTH_L) begin
                    fill_r <= fill_r + 1'b1;
                end
            end
        end
    end
`else
    logic echo_unused_s;

    assign echo_unused_s = ^{echo_fb, echo_dly};
    assign sum_s         = SW'(g_s);
    assign store_s       = (state_r == MUL);
`endif

    // Output sample for the current channel: raw input in bypass, otherwise the saturated sum.
    always_comb begin
        y_s      = x_s;
        y_clip_s = 1'b0;
        if (bypass_r) begin
            y_s      = x_s;
            y_clip_s = 1'b0;
        end else begin
            {y_clip_s, y_s} = sat_clip(sum_s);
        end
    end

    // FSM state register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state: one MUL (and ADD with echo) pass per channel, then DONE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = MUL;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            MUL: begin
`ifdef AUDIO_ECHO_EN
                state_nx_s = ADD;
`else
                if (last_ch_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = MUL;
                end
`endif
            end
            ADD: begin
                if (last_ch_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = MUL;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Frame capture, per-channel shadow update and output publication.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ch_r        <= '0;
            x_r         <= '0;
            gain_r      <= '0;
            bypass_r    <= 1'b0;
            shadow_r    <= '0;
            clip_sh_r   <= '0;
            out_data_r  <= '0;
            clip_r      <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            overrun_r   <= in_valid && busy_r;
            if (out_valid_r) begin
                busy_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        x_r      <= in_data;
                        gain_r   <= gain;
                        bypass_r <= bypass;
                        ch_r     <= '0;
                        busy_r   <= 1'b1;
                    end
                end
                DONE: begin
                    out_data_r  <= shadow_r;
                    clip_r      <= clip_sh_r;
                    out_valid_r <= 1'b1;
                end
                default: ;
            endcase
            if (store_s) begin
                shadow_r[int'(ch_r)*DW +: DW] <= y_s;
                clip_sh_r[ch_r]               <= y_clip_s;
                if (!last_ch_s) begin
                    ch_r <= ch_r + 1'b1;
                end
            end
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign clip      = clip_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_audio_loop_proc.sv
// tb_audio_loop_proc: scoreboard bench for audio_loop_proc with a frame-history reference model.
module tb_audio_loop_proc;
    localparam int DW    = 16;
    localparam int CH    = 2;
    localparam int GW    = 8;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
`ifdef AUDIO_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif
    localparam int LAT = ECHO ? 2*CH+2 : CH+2;

    logic              sys_clk  = 1'b0;
    logic              sys_rst  = 1'b1;
    logic [CH*DW-1:0]  in_data  = '0;
    logic              in_valid = 1'b0;
    logic [CH*GW-1:0]  gain     = '0;
    logic [7:0]        echo_fb  = '0;
    logic [AW-1:0]     echo_dly = '0;
    logic              bypass   = 1'b0;
    logic [CH*DW-1:0]  out_data;
    logic              out_valid;
    logic [CH-1:0]     clip;
    logic              busy;
    logic              overrun;

    typedef struct {
        logic [CH*DW-1:0] data;
        logic [CH-1:0]    clip;
        int               cyc;
    } exp_t;

    exp_t exp_q[$];
    int   hist[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    audio_loop_proc #(.DW(DW), .CH(CH), .GW(GW), .DEPTH(DEPTH)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .gain      (gain),
        .echo_fb   (echo_fb),
        .echo_dly  (echo_dly),
        .bypass    (bypass),
        .out_data  (out_data),
        .out_valid (out_valid),
        .clip      (clip),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic longint floordiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: every frame since reset is remembered; the echo taps the frame D back, if it exists.
    task automatic model_frame(input logic [CH*DW-1:0] x, input logic [CH*GW-1:0] g,
                               input logic [7:0] fb, input logic [AW-1:0] dly,
                               input logic byp, input int t);
        exp_t   e;
        int     n;
        int     d_len;
        longint xv, s, dv;
        n     = hist.size() / CH;
        d_len = (dly == '0) ? DEPTH : int'(dly);
        for (int c = 0; c < CH; c++) begin
            logic [DW-1:0] xs;
            xs = x[c*DW +: DW];
            xv = longint'($signed(xs));
            if (byp) begin
                s         = xv;
                e.clip[c] = 1'b0;
            end else begin
                s = floordiv(xv * longint'(g[c*GW +: GW]), 64);
                if (ECHO && n >= d_len) begin
                    dv = longint'(hist[(n - d_len)*CH + c]);
                    s  = s + floordiv(dv * longint'(fb), 256);
                end
                e.clip[c] = (s > 32767) || (s < -32768);
                if (s > 32767) s = 32767;
                else if (s < -32768) s = -32768;
            end
            e.data[c*DW +: DW] = s[DW-1:0];
            hist.push_back(int'(s));
        end
        e.cyc = t + LAT;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic apply(input logic [CH*DW-1:0] x, input logic [CH*GW-1:0] g,
                         input logic [7:0] fb, input logic [AW-1:0] dly,
                         input logic byp, input bit push);
        in_data  = x;
        gain     = g;
        echo_fb  = fb;
        echo_dly = dly;
        bypass   = byp;
        in_valid = 1'b1;
        if (push) model_frame(x, g, fb, dly, byp, cyc);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic frame(input logic [CH*DW-1:0] x, input logic [CH*GW-1:0] g,
                         input logic [7:0] fb, input logic [AW-1:0] dly, input logic byp);
        tick();
        apply(x, g, fb, dly, byp, 1'b1);
        check("busy_after_accept", {63'd0, busy}, 64'd1);
        repeat (LAT-1) tick();
    endtask

    task automatic reset_dut();
        sys_rst = 1'b1;
        repeat (2) tick();
        sys_rst = 1'b0;
        hist.delete();
    endtask

    // Monitor: every out_valid must match the oldest expected frame, including its arrival cycle.
    always @(negedge sys_clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_out_valid: got out_valid=1, expected no output (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 64'(out_data), 64'(e.data));
                check("clip", 64'(clip), 64'(e.clip));
                check("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        repeat (3) tick();
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_clip", 64'(clip), 64'd0);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_overrun", {63'd0, overrun}, 64'd0);
        sys_rst = 1'b0;
        hist.delete();

        frame(32'hEDCC_1234, 16'h4040, 8'd0, 10'd4, 1'b0);
        frame(32'hC000_4000, 16'hFFFF, 8'd0, 10'd4, 1'b0);
        frame(32'h7FFF_8001, 16'h0000, 8'd0, 10'd4, 1'b1);

        reset_dut();
        frame(32'h0000_1000, 16'h4040, 8'd128, 10'd4, 1'b0);
        for (int i = 1; i < 9; i++) frame(32'h0000_0000, 16'h4040, 8'd128, 10'd4, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [CH*DW-1:0] rx;
            logic [CH*GW-1:0] rg;
            rx = $urandom();
            rg = 16'($urandom_range(0, 65535));
            frame(rx, rg, 8'($urandom_range(0, 255)), 10'($urandom_range(0, 12)),
                  ($urandom_range(0, 7) == 0));
        end

        tick();
        apply(32'h1111_2222, 16'h4040, 8'd0, 10'd4, 1'b0, 1'b1);
        tick();
        apply(32'h3333_4444, 16'h4040, 8'd0, 10'd4, 1'b0, 1'b0);
        check("overrun_pulse", {63'd0, overrun}, 64'd1);
        tick();
        check("overrun_clear", {63'd0, overrun}, 64'd0);
        repeat (LAT-3) tick();

        tick();
        apply(32'h5555_6666, 16'h4040, 8'd0, 10'd4, 1'b0, 1'b0);
        tick();
        sys_rst = 1'b1;
        tick();
        check("midframe_rst_out_data", 64'(out_data), 64'd0);
        check("midframe_rst_clip", 64'(clip), 64'd0);
        check("midframe_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midframe_rst_busy", {63'd0, busy}, 64'd0);
        check("midframe_rst_overrun", {63'd0, overrun}, 64'd0);
        sys_rst = 1'b0;
        hist.delete();
        repeat (2*LAT) tick();

        for (int i = 0; i < 1025; i++) frame(32'h0100_0100, 16'h4040, 8'd255, 10'd0, 1'b0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
